// File: rtl/jesd204_tx_pkg.sv
// Shared types and control characters for the JESD204B TX link sequencer.
package jesd204_tx_pkg;

  typedef enum logic [1:0] {
    CGS  = 2'd0,
    ILAS = 2'd1,
    DATA = 2'd2
  } link_state_t;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;
  localparam logic [7:0] K28_7 = 8'hFC;

  // Octet 0 occupies bits [7:0] and is transmitted first.
  typedef logic [3:0][7:0]  octet_word_t;
  typedef logic [13:0][7:0] ilas_cfg_t;

endpackage

// File: rtl/jesd204_tx_link_seq_if.sv
// Configuration, user-data and character-replacement bus of the TX link sequencer.
interface jesd204_tx_link_seq_if;
  import jesd204_tx_pkg::*;

  logic [7:0]  F;
  logic [4:0]  K;
  ilas_cfg_t   CFG;
  octet_word_t DI;
  logic        DI_RDY;
  logic        EN;
  logic [3:0]  FE;
  logic [3:0]  ME;
  octet_word_t DO;
  logic        LINK_UP;

  modport master (output F, K, CFG, DI,
                  input  DI_RDY, EN, FE, ME, DO, LINK_UP);
  modport slave  (input  F, K, CFG, DI,
                  output DI_RDY, EN, FE, ME, DO, LINK_UP);

endinterface

// File: rtl/jesd204_sync_cdc.sv
// Multi-flop synchroniser for the asynchronous SYNC_n request; resets to 0 (request asserted).
module jesd204_sync_cdc #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // NOTE: clocked state always uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/jesd204_tx_link_seq.sv
// Per-lane JESD204B TX link sequencer: CGS -> ILAS -> DATA with free-running LMFC and FE/ME flags.
// Optional macro JESD_TX_SYSREF_EN adds a SYSREF input that realigns the LMFC and restarts the link.
module jesd204_tx_link_seq
  import jesd204_tx_pkg::*;
#(
  parameter int ILAS_MF     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic SYNC_n,
`ifdef JESD_TX_SYSREF_EN
  input  logic SYSREF,
`endif
  jesd204_tx_link_seq_if.slave lnk
);

  localparam logic [2:0] LAST_MF = 3'(ILAS_MF - 1);

  link_state_t r_state, w_next;
  logic [7:0]  r_f;
  logic [4:0]  r_k;
  ilas_cfg_t   r_cfg;
  logic [11:0] r_w;
  logic [5:0]  r_fw;
  logic [2:0]  r_m;
  logic        r_armed, r_low;
  octet_word_t r_do;
  logic [3:0]  r_fe, r_me;
  logic        r_live;

  logic        w_sync, w_sysref, w_w_last, w_resync, w_leave, w_live;
  logic [8:0]  w_fp1;
  logic [5:0]  w_kp1;
  logic [13:0] w_prod;
  logic [11:0] w_mfw_m1;
  octet_word_t w_do;
  logic [3:0]  w_fe, w_me;

  jesd204_sync_cdc #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clk   (CLK),
    .i_rst_n (RST_n),
    .i_d     (SYNC_n),
    .o_q     (w_sync)
  );

`ifdef JESD_TX_SYSREF_EN
  logic r_sysref_d;
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) r_sysref_d <= 1'b0;
    else        r_sysref_d <= SYSREF;
  end
  assign w_sysref = SYSREF & ~r_sysref_d;
`else
  assign w_sysref = 1'b0;
`endif

  // NOTE: r_cfg is a plain register bank, not a RAM, so it resets like any other flop.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_f   <= '0;
      r_k   <= '0;
      r_cfg <= '0;
    end else if (r_state == CGS) begin
      r_f   <= lnk.F;
      r_k   <= lnk.K;
      r_cfg <= lnk.CFG;
    end
  end

  // MFW-1 in words; the >= wrap keeps illegal configurations from running away.
  assign w_fp1    = {1'b0, r_f} + 9'd1;
  assign w_kp1    = {1'b0, r_k} + 6'd1;
  assign w_prod   = 14'(w_fp1) * 14'(w_kp1);
  assign w_mfw_m1 = 12'(w_prod >> 2) - 12'd1;
  assign w_w_last = (r_w >= w_mfw_m1);

  assign w_resync = (r_state != CGS) && !w_sync && r_low;
  assign w_leave  = (r_state != CGS) && (w_resync || w_sysref);
  assign w_live   = (r_state == DATA) && !w_leave;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_w     <= '0;
      r_fw    <= '0;
      r_m     <= '0;
      r_armed <= 1'b0;
      r_low   <= 1'b0;
    end else begin
      r_w     <= (w_sysref || w_w_last) ? '0 : r_w + 12'd1;
      r_fw    <= (w_sysref || w_w_last || r_fw >= r_f[7:2]) ? '0 : r_fw + 6'd1;
      r_armed <= (r_state == CGS) && w_sync;
      r_low   <= (r_state != CGS) && !w_sync;
      if (r_state != ILAS) r_m <= '0;
      else if (w_w_last)   r_m <= r_m + 3'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) r_state <= CGS;
    else        r_state <= w_next;
  end

  // Re-sync is tested before the ILAS exit so it wins when both fire together.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      CGS:     if (r_armed && w_sync && w_w_last) w_next = ILAS;
      ILAS:    if (w_leave) w_next = CGS;
               else if (w_w_last && r_m == LAST_MF) w_next = DATA;
      DATA:    if (w_leave) w_next = CGS;
      default: w_next = CGS;
    endcase
  end

  function automatic logic [7:0] ilas_octet(input logic [13:0] p, input logic last,
                                            input logic cfg_mf, input ilas_cfg_t cfg);
    logic [3:0] idx;
    idx = p[3:0] - 4'd2;
    if (p == 14'd0)                    return K28_0;
    else if (last)                     return K28_3;
    else if (cfg_mf && p == 14'd1)     return K28_4;
    else if (cfg_mf && p <= 14'd15)    return cfg[idx];
    return p[7:0];
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_do = {4{K28_5}};
    w_fe = '0;
    w_me = '0;
    if (r_state != CGS && !w_leave) begin
      w_me = {w_w_last, 3'b000};
      if (r_f == 8'd0)      w_fe = 4'b1111;
      else if (r_f == 8'd1) w_fe = 4'b1010;
      else                  w_fe = {r_fw == r_f[7:2], 3'b000};
      if (r_state == DATA) begin
        w_do = lnk.DI;
      end else begin
        for (int i = 0; i < 4; i++) begin
          w_do[i] = ilas_octet({r_w, 2'(i)}, w_w_last && (i == 3), r_m == 3'd1, r_cfg);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_do   <= '0;
      r_fe   <= '0;
      r_me   <= '0;
      r_live <= 1'b0;
    end else begin
      r_do   <= w_do;
      r_fe   <= w_fe;
      r_me   <= w_me;
      r_live <= w_live;
    end
  end

  assign lnk.DO      = r_do;
  assign lnk.FE      = r_fe;
  assign lnk.ME      = r_me;
  assign lnk.EN      = r_live;
  assign lnk.DI_RDY  = r_live;
  assign lnk.LINK_UP = r_live;

endmodule

// File: tb/tb_jesd204_tx_link_seq.sv
// Directed self-checking bench for jesd204_tx_link_seq (CGS, ILAS content, DATA, re-sync, SYSREF).
module tb_jesd204_tx_link_seq;
  import jesd204_tx_pkg::*;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic sync_n = 1'b0;
`ifdef JESD_TX_SYSREF_EN
  logic sysref = 1'b0;
`endif

  int          cyc      = 0;
  int          w_base   = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          di_n     = 0;
  octet_word_t di_q     = '0;
  ilas_cfg_t   cfg_v;
  bit          seen;

  jesd204_tx_link_seq_if lnk();

  jesd204_tx_link_seq #(.ILAS_MF(4), .SYNC_STAGES(2)) dut (
    .CLK    (clk),
    .RST_n  (rst_n),
    .SYNC_n (sync_n),
`ifdef JESD_TX_SYSREF_EN
    .SYSREF (sysref),
`endif
    .lnk    (lnk)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release; with MFW = 8 the DUT's W equals (cyc - w_base) mod 8.
  always @(posedge clk) if (rst_n) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_di();
    di_n++;
    di_q   = {8'(di_n * 3), 8'(di_n ^ 8'h5A), 8'(8'hC0 + di_n), 8'(di_n)};
    lnk.DI = di_q;
  endtask

  // A word visible at cycle c was formed when W = c-1.
  function automatic logic [3:0] exp_me();
    return (((cyc - 1 - w_base) % 8) == 7) ? 4'b1000 : 4'b0000;
  endfunction

  // ILAS word for MFW = 8 (32 octets per multiframe, last octet p = 31).
  function automatic octet_word_t ilas_word(input int w, input int m);
    octet_word_t r;
    for (int i = 0; i < 4; i++) begin
      int p;
      p = 4 * w + i;
      if (p == 0)                           r[i] = 8'h1C;
      else if (p == 31)                     r[i] = 8'h7C;
      else if (m == 1 && p == 1)            r[i] = 8'h9C;
      else if (m == 1 && p >= 2 && p <= 15) r[i] = cfg_v[p - 2];
      else                                  r[i] = 8'(p);
    end
    return r;
  endfunction

  task automatic data_step(input string tag);
    @(negedge clk);
    check({tag, "_do"}, lnk.DO, di_q);
    check({tag, "_link"}, lnk.LINK_UP, 1'b1);
    drive_di();
  endtask

  task automatic wait_ilas(input string tag);
    seen = 1'b0;
    for (int n = 0; n < 64 && !seen; n++) begin
      @(negedge clk);
      seen = (lnk.DO[0] == 8'h1C);
      if (!seen) drive_di();
    end
    check(tag, seen, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 14; i++) cfg_v[i] = 8'hA0 + 8'(i);
    lnk.F   = 8'd0;
    lnk.K   = 5'd31;
    lnk.CFG = cfg_v;
    lnk.DI  = '0;

    repeat (3) @(negedge clk);
    check("rst_do", lnk.DO, 32'h0);
    check("rst_ctl", {lnk.EN, lnk.FE, lnk.ME, lnk.DI_RDY, lnk.LINK_UP}, 11'h0);

    rst_n = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      check("cgs_do", lnk.DO, 32'hBCBC_BCBC);
      check("cgs_en_link", {lnk.EN, lnk.LINK_UP}, 2'b00);
      check("cgs_fe_me", {lnk.FE, lnk.ME}, 8'h00);
    end

    // Release SYNC_n at W = 3; ILAS must start on the next multiframe boundary.
    while ((cyc % 8) != 3) @(negedge clk);
    sync_n = 1'b1;
    wait_ilas("ilas_seen");
    check("ilas_start_w", (cyc - 1) % 8, 0);
    for (int j = 0; j < 32; j++) begin
      if (j > 0) @(negedge clk);
      check("ilas_do", lnk.DO, ilas_word(j % 8, j / 8));
      check("ilas_fe", lnk.FE, 4'b1111);
      check("ilas_me", lnk.ME, (j % 8 == 7) ? 4'b1000 : 4'b0000);
      check("ilas_en", lnk.EN, 1'b0);
      drive_di();
    end

    // Word 33 is the first DATA word: ILAS lasted exactly 32 cycles.
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      check("d0_do", lnk.DO, di_q);
      check("d0_ctl", {lnk.EN, lnk.DI_RDY, lnk.LINK_UP}, 3'b111);
      check("d0_fe", lnk.FE, 4'b1111);
      check("d0_me", lnk.ME, exp_me());
      drive_di();
    end

    sync_n = 1'b0;
    data_step("glitch");
    sync_n = 1'b1;
    repeat (6) data_step("glitch_ignored");

    sync_n = 1'b0;
    data_step("resync_a");
    data_step("resync_b");
    sync_n = 1'b1;
    lnk.F  = 8'd1;
    lnk.K  = 5'd15;
    data_step("resync_c");
    @(negedge clk);
    check("resync_do", lnk.DO, 32'hBCBC_BCBC);
    check("resync_link", {lnk.EN, lnk.LINK_UP}, 2'b00);

    // F = 1, K = 15 (MFW = 8): wait for DATA, then change config to show it is ignored.
    seen = 1'b0;
    for (int n = 0; n < 80 && !seen; n++) begin
      @(negedge clk);
      seen = lnk.EN;
      if (!seen) drive_di();
    end
    check("data1_seen", seen, 1'b1);
    lnk.F = 8'd0;
    lnk.K = 5'd3;
    for (int n = 0; n < 16; n++) begin
      if (n > 0) @(negedge clk);
      check("d1_do", lnk.DO, di_q);
      check("d1_fe", lnk.FE, 4'b1010);
      check("d1_me", lnk.ME, exp_me());
      drive_di();
    end
    lnk.F = 8'd1;
    lnk.K = 5'd15;

`ifdef JESD_TX_SYSREF_EN
    while (((cyc - w_base) % 8) != 5) data_step("pre_sysref");
    sysref = 1'b1;
    @(negedge clk);
    sysref = 1'b0;
    w_base = cyc;
    check("sysref_do", lnk.DO, 32'hBCBC_BCBC);
    check("sysref_link", lnk.LINK_UP, 1'b0);
    wait_ilas("sysref_ilas_seen");
    check("sysref_ilas_w", (cyc - 1 - w_base) % 8, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/jesd204_tx_link_seq.md
Name: jesd204_tx_link_seq

Overview:
- Per-lane JESD204B TX link-layer sequencer with a 4-octet-per-clock datapath.
- Runs the link through code-group synchronisation (CGS), the initial lane alignment sequence (ILAS) and user data.
- Maintains the local frame and multiframe (LMFC) counters and produces the registered octet word plus the EN/FE/ME control consumed by the downstream character-replacement stage.

Parameters:
- ILAS_MF, 4, number of ILAS multiframes (legal range 4..8).
- SYNC_STAGES, 2, synchroniser depth for SYNC_n (minimum 2).

Ports:
- CLK  input  1  link clock, one 4-octet word per cycle.
- RST_n  input  1  asynchronous active-low reset.
- SYNC_n  input  1  receiver SYNC request, asynchronous, active low.
- F  input  8  octets per frame minus 1; legal values 0, 1, 3, 7, 11, ...
- K  input  5  frames per multiframe minus 1.
- CFG  input  14x8  ILAS link-configuration octets 0..13.
- DI  input  4x8  user data word; octet 0 is the first transmitted octet.
- DI_RDY  output  1  high while the block consumes DI (DATA state).
- EN  output  1  data-phase enable for character replacement.
- FE  output  4  frame-end flag per octet.
- ME  output  4  multiframe-end flag per octet.
- DO  output  4x8  octet word to character replacement.
- LINK_UP  output  1  high in DATA state.

Behaviour:
- Reset (async): all outputs 0; state CGS; LMFC counters 0; synchroniser flops reset to 0, so SYNC_n reads as asserted.
- Config: F, K and CFG are latched only while in CGS. Changes in other states are ignored.
- Legality: (F+1)*(K+1) must be a multiple of 4 and at most 256. Illegal values give undefined output and must not cause lockup.
- LMFC word counter W:
  - Counts 0..MFW-1, where MFW = (F+1)*(K+1)/4.
  - Free-runs in all states and wraps to 0.
  - Word position p = 4*W + i for octet lane i.
- Flags:
  - FE[i] = ((p mod (F+1)) == F).
  - ME[i] = (p == 4*MFW-1).
- Output timing: DO, EN, FE, ME, DI_RDY and LINK_UP are all registered and mutually aligned, one cycle after the state/counter/DI they derive from.
- CGS state:
  - DO = BC BC BC BC (K28.5); EN = 0; FE = ME = 0.
  - On synchronised SYNC_n = 1, arm; when W reaches MFW-1, go to ILAS, so ILAS starts at W = 0.
  - If SYNC_n falls while armed, disarm.
- ILAS state:
  - Runs ILAS_MF multiframes, counted by MF counter m.
  - Octet p = 0 → 1C (K28.0); p = last → 7C (K28.3); other octets → p[7:0] ramp.
  - When m = 1, octet 1 = 9C (K28.4) and octets 2..15 = CFG[0..13].
  - EN = 0; FE and ME are driven per the formulas above.
  - After the last word of multiframe ILAS_MF-1, go to DATA.
- DATA state:
  - DO = DI from the previous cycle; EN = 1; DI_RDY = 1; LINK_UP = 1.
- Re-sync: synchronised SYNC_n = 0 for 2 consecutive cycles in ILAS or DATA → CGS, and DO = BC words from the next registered output. A single-cycle low is ignored.
- Simultaneous events: re-sync has priority over the ILAS→DATA transition on the same cycle.

Optional Feature:
- Macro JESD_TX_SYSREF_EN.
- Defined: adds input port SYSREF (1 bit, synchronous to CLK). A rising edge forces W to 0 on the next cycle. An edge in ILAS or DATA also forces a return to CGS.
- Undefined: no SYSREF port; the LMFC counter free-runs from reset.

Decomposition:
- Package jesd204_tx_pkg holds:
  - the state enum {CGS, ILAS, DATA};
  - control-character constants K28_5 = BC, K28_0 = 1C, K28_3 = 7C, K28_4 = 9C, K28_7 = FC;
  - the octet-word typedef (4x8).
- One sub-module, jesd204_sync_cdc, is the SYNC_STAGES-deep synchroniser with reset value 0.
- The LMFC counter and flag logic stay inline.

Test Plan:
- Reset with SYNC_n = 0, F = 0, K = 31 → DO, EN, FE, ME all 0 during reset; after release DO = BCBCBCBC, EN = 0, LINK_UP = 0 indefinitely.
- F = 0, K = 31 (MFW = 8); raise SYNC_n at W = 3 → first ILAS word has DO[0] = 1C and starts at W = 0; word 7 has DO[3] = 7C and ME = 1000; FE = 1111 on every ILAS word.
- Same configuration, second multiframe → octet 1 = 9C; octets 2..15 = CFG[0..13]; ILAS lasts exactly 32 cycles (ILAS_MF = 4).
- DATA with F = 1, K = 15 → EN = 1; DO equals DI delayed by 1 cycle; FE = 1010 on every word; ME = 1000 every 8th word.
- In DATA, drive SYNC_n low for 1 cycle then for 2 cycles → the first pulse is ignored; after the second, DO = BCBCBCBC and LINK_UP = 0.
- With JESD_TX_SYSREF_EN, pulse SYSREF at W = 5 in DATA → W = 0 on the next cycle, the state returns to CGS, and ILAS re-aligns to the new LMFC.
